// File: rtl/cpu_run_ctrl_if.sv
// Run-control bundle between the CPU run controller and its surroundings
// (mode select, step/tick sources, breakpoint, CPU enable and status).
interface cpu_run_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       clkSel;
    logic             stepPulse;
    logic             tick1Hz;
    logic             tick10Hz;
    logic             resumePulse;
    logic [11:0]      pcAddr;
    logic [11:0]      bpAddr;
    logic             bpEn;
    logic             cpuEn;
    logic [1:0]       state;
    logic [CNT_W-1:0] instCount;

    modport master (
        output clkSel, stepPulse, tick1Hz, tick10Hz, resumePulse,
        output pcAddr, bpAddr, bpEn,
        input  cpuEn, state, instCount
    );

    modport slave (
        input  clkSel, stepPulse, tick1Hz, tick10Hz, resumePulse,
        input  pcAddr, bpAddr, bpEn,
        output cpuEn, state, instCount
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: step/1 Hz/10 Hz/full-speed clock enable with a dead gap
// on mode changes; breakpoint/HALT logic present only with CPU_RUN_CTRL_BKPT_EN.
module cpu_run_ctrl #(
    parameter int CNT_W = 16,
    parameter int GAP   = 2
) (
    input  logic         clk,
    input  logic         rst,
    cpu_run_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HALT   = 2'b01,
        ST_SWITCH = 2'b10
    } state_t;

    state_t           state_q;
    logic [1:0]       mode_reg_q;
    logic             init_q;
    logic [3:0]       gap_q;
    logic             skip_bp_q;
    logic [CNT_W-1:0] inst_count_q;

    logic             mode_chg_s;
    logic             src_s;
    logic             bp_hit_s;
    logic             cpu_en_s;

    // init_q masks the first cycle after reset, while mode_reg_q is still unloaded.
    assign mode_chg_s = !init_q && (bus.clkSel != mode_reg_q);

`ifdef CPU_RUN_CTRL_BKPT_EN
    assign bp_hit_s = bus.bpEn && (bus.pcAddr == bus.bpAddr) && !skip_bp_q;
`else
    logic unused_bkpt_s;
    assign bp_hit_s      = 1'b0;
    assign unused_bkpt_s = ^{bus.bpAddr, bus.bpEn, bus.resumePulse};
`endif

    // Run source selected by the live mode; it equals mode_reg_q whenever cpuEn may fire.
    always_comb begin
        src_s = 1'b0;
        case (bus.clkSel)
            2'b00:   src_s = bus.stepPulse;
            2'b01:   src_s = bus.tick1Hz;
            2'b10:   src_s = bus.tick10Hz;
            2'b11:   src_s = 1'b1;
            default: src_s = 1'b0;
        endcase
    end

    // CPU enable: mode change and reset win over every other source.
    always_comb begin
        cpu_en_s = 1'b0;
        if (rst || mode_chg_s) begin
            cpu_en_s = 1'b0;
        end else begin
            case (state_q)
                ST_RUN:  cpu_en_s = src_s && !bp_hit_s;
                ST_HALT: cpu_en_s = bus.stepPulse;
                default: cpu_en_s = 1'b0;
            endcase
        end
    end

    // Run-control FSM, gap counter, breakpoint skip flag and instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            mode_reg_q   <= 2'b00;
            init_q       <= 1'b1;
            gap_q        <= 4'd0;
            skip_bp_q    <= 1'b0;
            inst_count_q <= {CNT_W{1'b0}};
        end else begin
            mode_reg_q <= bus.clkSel;
            init_q     <= 1'b0;

            if (cpu_en_s && (inst_count_q != {CNT_W{1'b1}})) begin
                inst_count_q <= inst_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            if (mode_chg_s) begin
                state_q   <= ST_SWITCH;
                gap_q     <= 4'(GAP);
                skip_bp_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (bp_hit_s) begin
                            state_q   <= ST_HALT;
                            skip_bp_q <= 1'b0;
                        end else if (skip_bp_q && (bus.pcAddr != bus.bpAddr)) begin
                            skip_bp_q <= 1'b0;
                        end
                    end
                    ST_HALT: begin
                        // Skip the breakpoint once so the halted instruction can execute.
                        if (bus.resumePulse) begin
                            state_q   <= ST_RUN;
                            skip_bp_q <= 1'b1;
                        end
                    end
                    ST_SWITCH: begin
                        if (gap_q <= 4'd1) begin
                            state_q <= ST_RUN;
                            gap_q   <= 4'd0;
                        end else begin
                            gap_q <= gap_q - 4'd1;
                        end
                    end
                    default: begin
                        state_q <= ST_RUN;
                        gap_q   <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign bus.cpuEn     = cpu_en_s;
    assign bus.state     = state_q;
    assign bus.instCount = inst_count_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: a cycle model pushes expected outputs when
// stimulus is applied; the negedge monitor pops and compares them.
module tb_cpu_run_ctrl;
    localparam int GAP = 2;
`ifdef CPU_RUN_CTRL_BKPT_EN
    localparam bit BK = 1'b1;
`else
    localparam bit BK = 1'b0;
`endif

    typedef struct {
        logic        en;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst4 = 1'b1;

    cpu_run_ctrl_if #(.CNT_W(16)) bus ();
    cpu_run_ctrl_if #(.CNT_W(4))  bus4 ();

    cpu_run_ctrl #(.CNT_W(16), .GAP(GAP)) dut  (.clk(clk), .rst(rst),  .bus(bus));
    cpu_run_ctrl #(.CNT_W(4),  .GAP(GAP)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb_q[$];
    int          en_seen = 0;
    logic [11:0] pc = 12'd0;
    logic        bp_en_v = 1'b0;
    logic [11:0] bp_addr_v = 12'd0;

    logic [1:0]  m_state;
    logic [1:0]  m_mode;
    bit          m_init;
    int          m_gap;
    bit          m_skip;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Monitor: compare this cycle's outputs with the model; the "CPU" advances PC on cpuEn.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("cpuEn", {31'd0, bus.cpuEn}, {31'd0, e.en});
            chk("state", {30'd0, bus.state}, {30'd0, e.st});
            chk("instCount", {16'd0, bus.instCount}, {16'd0, e.cnt});
        end
        en_seen <= en_seen + int'(bus.cpuEn);
        pc      <= pc + {11'd0, bus.cpuEn};
    end

    task automatic drive(input logic [1:0] sel, input logic stp, input logic t1,
                         input logic t10, input logic res, input logic r);
        exp_t e;
        logic chg, src, hit, en;
        @(posedge clk);
        #1;
        rst = r;
        bus.clkSel = sel; bus.stepPulse = stp; bus.tick1Hz = t1; bus.tick10Hz = t10;
        bus.resumePulse = res; bus.pcAddr = pc; bus.bpEn = bp_en_v; bus.bpAddr = bp_addr_v;
        if (r) begin
            e = '{1'b0, 2'b00, 16'd0};
            sb_q.push_back(e);
            m_state = 2'b00; m_init = 1'b1; m_gap = 0; m_skip = 1'b0; m_cnt = 0;
            return;
        end
        chg = !m_init && (sel != m_mode);
        case (sel)
            2'b00:   src = stp;
            2'b01:   src = t1;
            2'b10:   src = t10;
            default: src = 1'b1;
        endcase
        hit = BK && bp_en_v && (pc == bp_addr_v) && !m_skip;
        en = 1'b0;
        if (!chg && m_state == 2'b00) en = src && !hit;
        else if (!chg && m_state == 2'b01) en = stp;
        e = '{en, m_state, m_cnt[15:0]};
        sb_q.push_back(e);
        if (en && m_cnt < 65535) m_cnt++;
        if (chg) begin
            m_state = 2'b10; m_gap = GAP; m_skip = 1'b0;
        end else if (m_state == 2'b00) begin
            if (hit) begin m_state = 2'b01; m_skip = 1'b0; end
            else if (pc != bp_addr_v) m_skip = 1'b0;
        end else if (m_state == 2'b01) begin
            if (res) begin m_state = 2'b00; m_skip = 1'b1; end
        end else begin
            m_gap--;
            if (m_gap == 0) m_state = 2'b00;
        end
        m_mode = sel;
        m_init = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int base, cbase;
        logic [11:0] pbase;
        logic [1:0] sel_v;
        bus.clkSel = 2'b11; bus.stepPulse = 1'b0; bus.tick1Hz = 1'b0; bus.tick10Hz = 1'b0;
        bus.resumePulse = 1'b0; bus.pcAddr = 12'd0; bus.bpAddr = 12'd0; bus.bpEn = 1'b0;
        bus4.clkSel = 2'b11; bus4.stepPulse = 1'b0; bus4.tick1Hz = 1'b0; bus4.tick10Hz = 1'b0;
        bus4.resumePulse = 1'b0; bus4.pcAddr = 12'd0; bus4.bpAddr = 12'd0; bus4.bpEn = 1'b0;

        // 4-bit counter saturation, then reset in the middle of SWITCH
        @(posedge clk); #1;
        chk("rst4_state", {30'd0, bus4.state}, 32'd0);
        chk("rst4_en", {31'd0, bus4.cpuEn}, 32'd0);
        rst4 = 1'b0;
        repeat (20) @(posedge clk);
        settle();
        chk("sat4_cnt", {28'd0, bus4.instCount}, 32'd15);
        @(posedge clk); #1;
        bus4.clkSel = 2'b00;
        settle();
        chk("chg4_en", {31'd0, bus4.cpuEn}, 32'd0);
        @(posedge clk); #1;
        chk("sw4_state", {30'd0, bus4.state}, 32'd2);
        rst4 = 1'b1;
        #1;
        chk("rst4_sw_state", {30'd0, bus4.state}, 32'd0);
        chk("rst4_sw_en", {31'd0, bus4.cpuEn}, 32'd0);
        chk("rst4_sw_cnt", {28'd0, bus4.instCount}, 32'd0);

        // full speed, no breakpoint: 10 pulses in 10 cycles
        drive(2'b11, 0, 0, 0, 0, 1);
        drive(2'b11, 0, 0, 0, 0, 1);
        settle();
        base = en_seen;
        repeat (10) drive(2'b11, 0, 0, 0, 0, 0);
        drive(2'b00, 0, 0, 0, 0, 0);
        settle();
        chk("a_pulses", en_seen - base, 32'd10);
        chk("a_cnt", {16'd0, bus.instCount}, 32'd10);

        // full speed with a breakpoint 5 instructions ahead
        drive(2'b11, 0, 0, 0, 0, 1);
        settle();
        pbase = pc; base = en_seen;
        bp_en_v = 1'b1; bp_addr_v = pbase + 12'd5;
        repeat (12) drive(2'b11, 0, 0, 0, 0, 0);
        settle();
        chk("b_pulses", en_seen - base, BK ? 32'd5 : 32'd12);
        chk("b_state", {30'd0, bus.state}, BK ? 32'd1 : 32'd0);
        chk("b_pc", {20'd0, pc}, BK ? {20'd0, pbase + 12'd5} : {20'd0, pbase + 12'd12});
        drive(2'b11, 0, 0, 0, 1, 0);
        settle();
        chk("b_res_en", {31'd0, bus.cpuEn}, BK ? 32'd0 : 32'd1);
        pbase = pc;
        drive(2'b11, 0, 0, 0, 0, 0);
        drive(2'b11, 0, 0, 0, 0, 0);
        settle();
        chk("b_pass_pc", {20'd0, pc}, {20'd0, pbase + 12'd2});
        chk("b_nohalt", {30'd0, bus.state}, 32'd0);
        bp_en_v = 1'b0;

        // 1 Hz -> full speed with a coincident tick: tick dropped, 2-cycle gap
        drive(2'b01, 0, 0, 0, 0, 1);
        drive(2'b01, 0, 1, 0, 0, 0);
        drive(2'b01, 0, 0, 1, 0, 0);
        drive(2'b01, 0, 1, 0, 0, 0);
        drive(2'b11, 0, 1, 0, 0, 0);
        settle();
        chk("c_drop_en", {31'd0, bus.cpuEn}, 32'd0);
        drive(2'b11, 0, 0, 0, 0, 0);
        settle();
        chk("c_sw1", {30'd0, bus.state}, 32'd2);
        drive(2'b11, 0, 0, 0, 0, 0);
        settle();
        chk("c_sw2", {30'd0, bus.state}, 32'd2);
        drive(2'b11, 0, 0, 0, 0, 0);
        settle();
        chk("c_resume_en", {31'd0, bus.cpuEn}, 32'd1);
        chk("c_resume_st", {30'd0, bus.state}, 32'd0);

        // step mode sitting on a breakpoint: three steps in HALT, ticks ignored
        drive(2'b00, 0, 0, 0, 0, 1);
        settle();
        bp_en_v = 1'b1; bp_addr_v = pc;
        drive(2'b00, 0, 1, 1, 0, 0);
        settle();
        base = en_seen; cbase = int'(bus.instCount);
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 1, 1, 1, 0, 0);
            drive(2'b00, 0, 1, 1, 0, 0);
        end
        settle();
        chk("d_pulses", en_seen - base, 32'd3);
        chk("d_cnt", int'(bus.instCount) - cbase, 32'd3);
        chk("d_state", {30'd0, bus.state}, BK ? 32'd1 : 32'd0);
        drive(2'b00, 1, 0, 0, 0, 1);
        drive(2'b00, 0, 0, 0, 0, 0);

        // randomised traffic against the model
        sel_v = 2'b11;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) sel_v = 2'($urandom_range(0, 3));
            if (i % 20 == 0) begin
                bp_en_v = 1'($urandom_range(0, 1));
                bp_addr_v = pc + 12'($urandom_range(0, 3));
            end
            drive(sel_v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), (i == 150));
        end
        settle();
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
